// File: rtl/spram_arbiter_if.sv
// Request/response channel between one client engine and spram_arbiter.
// The client drives the request fields and the arbiter returns ready and read data.
interface spram_arbiter_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic              valid;
    logic              ready;
    logic              wen;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic              rvalid;
    logic [DWIDTH-1:0] rdata;

    modport master (
        output valid, wen, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, wen, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// Two-client round-robin arbiter that owns a single-port block RAM.
// After reset it zero-fills the RAM, then grants one access per cycle.
module spram_arbiter #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    spram_arbiter_if.slave    a,
    spram_arbiter_if.slave    b,
    output logic              ram_en,
    output logic              ram_wen,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_datai,
    input  logic [DWIDTH-1:0] ram_datao,
    output logic              init_done
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic       GNT_A   = 1'b0;
    localparam logic       GNT_B   = 1'b1;
    localparam logic [AWIDTH-1:0] CNT_LAST = AWIDTH'(MEM_DEPTH - 1);

    logic [0:0]        r_state;
    logic [AWIDTH-1:0] r_init_cnt;
    logic              r_last_grant;
    logic              r_rd_pending;
    logic              r_rd_owner;
    logic              r_init_done;

    logic w_run;
    logic w_init;
    logic w_gnt_a;
    logic w_gnt_b;

    // rst gates the combinational outputs so the reset cycle itself is quiet
    assign w_run   = (r_state == ST_RUN) && !rst;
    assign w_init  = (r_state == ST_INIT) && !rst;
    assign w_gnt_a = w_run && a.valid && (!b.valid || (r_last_grant == GNT_B));
    assign w_gnt_b = w_run && b.valid && !w_gnt_a;

    assign a.ready = w_gnt_a;
    assign b.ready = w_gnt_b;

    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_datai = '0;
        if (w_init) begin
            ram_en   = 1'b1;
            ram_wen  = 1'b1;
            ram_addr = r_init_cnt;
        end else if (w_gnt_a) begin
            ram_en    = 1'b1;
            ram_wen   = a.wen;
            ram_addr  = a.addr;
            ram_datai = a.wdata;
        end else if (w_gnt_b) begin
            ram_en    = 1'b1;
            ram_wen   = b.wen;
            ram_addr  = b.addr;
            ram_datai = b.wdata;
        end
    end

    // The RAM output is already registered, so the response is a pure pass-through
    assign a.rvalid = r_rd_pending && (r_rd_owner == GNT_A) && !rst;
    assign b.rvalid = r_rd_pending && (r_rd_owner == GNT_B) && !rst;
    assign a.rdata  = a.rvalid ? ram_datao : '0;
    assign b.rdata  = b.rvalid ? ram_datao : '0;
    assign init_done = r_init_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_last_grant <= GNT_B;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= GNT_A;
            r_init_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == CNT_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_gnt_a) begin
                        r_last_grant <= GNT_A;
                    end else if (w_gnt_b) begin
                        r_last_grant <= GNT_B;
                    end
                end
            endcase
            r_rd_pending <= (w_gnt_a && !a.wen) || (w_gnt_b && !b.wen);
            r_rd_owner   <= w_gnt_b ? GNT_B : GNT_A;
        end
    end
endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a behavioural registered-output RAM.
// Stimulus pushes expected read responses; a monitor pops them on rvalid.
module tb_spram_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ram_en;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_datai;
    logic [DW-1:0] ram_datao;
    logic          init_done;

    spram_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) a_if ();
    spram_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW)) b_if ();

    spram_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a_if),
        .b         (b_if),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_datai (ram_datai),
        .ram_datao (ram_datao),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Behavioural blk_ram: registered read, preloaded with garbage so the sweep matters
    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hC3;
        ram_datao = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) mem[ram_addr] <= ram_datai;
            else         ram_datao <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest pending expectation
    always @(negedge clk) begin
        rsp_t e;
        if (a_if.rvalid || b_if.rvalid) begin
            check("rvalid_exclusive", {31'd0, a_if.rvalid && b_if.rvalid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {30'd0, a_if.rvalid, b_if.rvalid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner", {31'd0, b_if.rvalid}, {31'd0, e.owner});
                check("rsp_data", {24'd0, (e.owner ? b_if.rdata : a_if.rdata)}, {24'd0, e.data});
            end
        end
    end

    // Call just after a posedge; returns just after the posedge that accepted the request.
    task automatic req(input bit who, input bit wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
        bit done = 0;
        if (who) begin
            b_if.valid = 1; b_if.wen = wen; b_if.addr = addr; b_if.wdata = wdata;
        end else begin
            a_if.valid = 1; a_if.wen = wen; a_if.addr = addr; a_if.wdata = wdata;
        end
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if ((who ? b_if.ready : a_if.ready) === 1'b1) begin
                done = 1;
                if (!wen) exp_q.push_back('{owner: who, data: exp});
            end
            @(posedge clk); #1;
        end
        if (!done) check("req_timeout", 32'd0, 32'd1);
        if (who) b_if.valid = 0; else a_if.valid = 0;
    endtask

    task automatic wait_init(input string name);
        bit seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (init_done === 1'b1) seen = 1;
        end
        check(name, {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        a_if.valid = 0; a_if.wen = 0; a_if.addr = '0; a_if.wdata = '0;
        b_if.valid = 0; b_if.wen = 0; b_if.addr = '0; b_if.wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", {30'd0, a_if.ready, b_if.ready}, 32'd0);
        check("rst_rvalid", {30'd0, a_if.rvalid, b_if.rvalid}, 32'd0);
        check("rst_ram_en_wen", {30'd0, ram_en, ram_wen}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);

        // Init sweep with A holding a read of 0x10
        @(posedge clk); #1;
        rst = 0;
        a_if.valid = 1; a_if.wen = 0; a_if.addr = 8'h10;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            check("sweep_pins", {13'd0, ram_en, ram_wen, ram_addr, ram_datai, a_if.ready, init_done},
                  {13'd0, 1'b1, 1'b1, i[7:0], 8'h00, 1'b0, 1'b0});
        end
        @(negedge clk);
        check("run_first", {14'd0, init_done, a_if.ready, ram_en, ram_wen, ram_addr},
              {14'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10});
        exp_q.push_back('{owner: 1'b0, data: 8'h00});
        @(posedge clk); #1;
        a_if.valid = 0;
        @(posedge clk); #1;

        // Single write then read, back to back
        req(0, 1, 8'h22, 8'h5A, 8'h00);
        req(0, 0, 8'h22, 8'h00, 8'h5A);

        // Preload for contention; B last so A has priority next
        req(0, 1, 8'h01, 8'h11, 8'h00);
        req(1, 1, 8'h02, 8'h22, 8'h00);

        // Contention: both hold reads for four cycles -> A, B, A, B
        a_if.valid = 1; a_if.wen = 0; a_if.addr = 8'h01;
        b_if.valid = 1; b_if.wen = 0; b_if.addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("contend_grant", {30'd0, a_if.ready, b_if.ready},
                  (k % 2 == 0) ? 32'd2 : 32'd1);
            exp_q.push_back((k % 2 == 0) ? '{owner: 1'b0, data: 8'h11}
                                          : '{owner: 1'b1, data: 8'h22});
            @(posedge clk); #1;
        end
        a_if.valid = 0; b_if.valid = 0;

        // Mixed contention setup: 0x40 holds 0x33, then A is last granted
        req(1, 1, 8'h40, 8'h33, 8'h00);
        req(0, 0, 8'h01, 8'h00, 8'h11);
        a_if.valid = 1; a_if.wen = 1; a_if.addr = 8'h40; a_if.wdata = 8'h77;
        b_if.valid = 1; b_if.wen = 0; b_if.addr = 8'h40;
        @(negedge clk);
        check("mixed_b_first", {29'd0, a_if.ready, b_if.ready, ram_wen}, 32'b010);
        exp_q.push_back('{owner: 1'b1, data: 8'h33});
        @(posedge clk); #1;
        b_if.valid = 0;
        @(negedge clk);
        check("mixed_a_write", {21'd0, a_if.ready, ram_wen, ram_addr, ram_datai[0+:1]},
              {21'd0, 1'b1, 1'b1, 8'h40, 1'b1});
        @(posedge clk); #1;
        a_if.valid = 0;
        req(1, 0, 8'h40, 8'h00, 8'h77);

        // Idle: RAM pins all quiet; last_grant (B) must survive
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_pins", {14'd0, ram_en, ram_wen, ram_addr, ram_datai}, 32'd0);
        end
        @(posedge clk); #1;
        a_if.valid = 1; a_if.wen = 0; a_if.addr = 8'h22;
        b_if.valid = 1; b_if.wen = 0; b_if.addr = 8'h02;
        @(negedge clk);
        check("idle_keeps_last", {30'd0, a_if.ready, b_if.ready}, 32'd2);
        exp_q.push_back('{owner: 1'b0, data: 8'h5A});
        @(posedge clk); #1;
        a_if.valid = 0;
        @(negedge clk);
        check("b_after_a", {31'd0, b_if.ready}, 32'd1);
        exp_q.push_back('{owner: 1'b1, data: 8'h22});
        @(posedge clk); #1;
        b_if.valid = 0;
        @(posedge clk); #1;

        // Reset one cycle after an accepted read: that read never answers
        req(0, 1, 8'h50, 8'h99, 8'h00);
        req(0, 0, 8'h50, 8'h00, 8'h99);
        void'(exp_q.pop_back());
        rst = 1;
        @(negedge clk);
        check("rst_kills_rvalid", {30'd0, a_if.rvalid, b_if.rvalid}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("sweep_restart", {22'd0, ram_en, ram_wen, ram_addr}, {22'd0, 1'b1, 1'b1, 8'h00});
        @(posedge clk); #1;
        wait_init("reinit_done");
        req(0, 0, 8'h50, 8'h00, 8'h00);

        // Drain outstanding responses
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
